muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand/result width in bits (legal: even, >= 8).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1, request to begin an operation on A, B, Op.
REQ-005 SHALL have port Op, input, 3, operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have ports A and B, input, WIDTH each, operands (signedness per Op).
REQ-007 SHALL have port result, output, WIDTH, registered result.
REQ-008 SHALL have port busy, output, 1, high while an operation is in flight.
REQ-009 SHALL have port done, output, 1, one-cycle pulse marking result valid.
REQ-010 SHALL have ports Zero and Sign, output, 1 each: Zero = (result == 0), Sign = result[WIDTH-1], combinational from the result register.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, FIX, DONE; busy = 1 in CALC and FIX only.
REQ-012 SHALL accept start only when busy = 0 (IDLE or DONE); A, B, Op captured on that edge; later changes to the inputs SHALL NOT affect the operation.
REQ-013 SHALL ignore start while busy = 1 (no restart, no queuing).
REQ-014 IDLE/DONE + accepted start -> CALC; CALC runs exactly WIDTH cycles (iterative shift-add multiply / restoring divide on magnitudes, one bit per cycle) -> FIX (sign correction, result load) -> DONE -> IDLE unless a new start is accepted.
REQ-015 Latency: done SHALL be high in the cycle WIDTH+2 rising edges after the edge that accepted start; done high for exactly one cycle.
REQ-016 result SHALL update only on the FIX->DONE edge and hold until the next FIX->DONE edge or reset.
REQ-017 MUL SHALL return the low WIDTH bits of the product; MULH/MULHSU/MULHU the high WIDTH bits of the 2*WIDTH-bit signed*signed / signed*unsigned / unsigned*unsigned product.
REQ-018 DIV/REM SHALL truncate toward zero; remainder sign equals the dividend's sign.
REQ-019 Divide by zero: DIV/DIVU result = all ones; REM/REMU result = A.
REQ-020 Signed overflow (DIV/REM, A = most negative, B = -1): DIV result = A; REM result = 0.
REQ-021 A start accepted in DONE SHALL leave that cycle's done pulse intact and enter CALC on the same edge.

Reset
REQ-022 reset SHALL force state IDLE, result = 0, busy = 0, done = 0 (hence Zero = 1, Sign = 0) on the next rising edge, including mid-operation; an aborted operation SHALL never produce a done pulse.
REQ-023 reset SHALL take priority over start on the same edge.

Configuration
REQ-024 Macro MULDIV_EARLY_OUT_EN: when defined, divide-by-zero and signed-overflow cases (REQ-019/020) SHALL skip CALC (IDLE/DONE -> FIX -> DONE), done 2 edges after start; all other ops unchanged.
REQ-025 When MULDIV_EARLY_OUT_EN is undefined, every Op including REQ-019/020 cases SHALL take WIDTH+2 edges; results identical in both builds.

Verification (WIDTH = 32)
REQ-026 MUL A=7, B=0xFFFFFFFD -> done at edge 34 after start, result 0xFFFFFFEB, Sign=1, Zero=0; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH 0x80000000*0x80000000 -> 0x40000000.
REQ-027 DIV A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC; REM 6/3 -> 0, Zero=1.
REQ-028 DIVU B=0 -> 0xFFFFFFFF; REMU A=0x1234, B=0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0; with MULDIV_EARLY_OUT_EN each done at edge 2, without at edge 34.
REQ-029 start held high continuously with changing A/B -> second op starts only in the DONE cycle; operands captured then; mid-op operand changes have no effect on result.
REQ-030 reset asserted in 5th CALC cycle of a DIV -> next edge busy=0, done=0, result=0; no done pulse follows; fresh MUL 3*5 afterward -> 15 at edge 34.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Optional macro MULDIV_EARLY_OUT_EN lets divide-by-zero and signed overflow skip CALC.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             Zero,
    output logic             Sign
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, bmag_q, bmag_d, a_q, a_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
    logic             divz_q, divz_d, ovf_q, ovf_d;

    logic             accept, signed_a, signed_b, a_neg, b_neg, divz_in, ovf_in;
    logic [WIDTH-1:0] a_mag, b_mag, quo, rem, fix_val;
    logic [WIDTH:0]   mul_sum, r_shift;
    logic [2*WIDTH-1:0] prod, prod_s;

    assign accept   = start && (state_q == StIdle || state_q == StDone);
    assign signed_a = Op[2] ? ~Op[0] : ~(Op[1] & Op[0]);
    assign signed_b = Op[2] ? ~Op[0] : ~Op[1];
    assign a_neg    = signed_a & A[WIDTH-1];
    assign b_neg    = signed_b & B[WIDTH-1];
    assign a_mag    = a_neg ? -A : A;
    assign b_mag    = b_neg ? -B : B;
    assign divz_in  = Op[2] && (B == '0);
    assign ovf_in   = Op[2] && !Op[0] && (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);

    assign mul_sum  = {1'b0, hi_q} + {1'b0, bmag_q};
    assign r_shift  = {hi_q, lo_q[WIDTH-1]};

    assign prod     = {hi_q, lo_q};
    assign prod_s   = neg_res_q ? -prod : prod;
    assign quo      = neg_res_q ? -lo_q : lo_q;
    assign rem      = neg_rem_q ? -hi_q : hi_q;

    // Special cases override the datapath, so both builds give identical results.
    always_comb begin
        fix_val = '0;
        if (divz_q) begin
            fix_val = op_q[1] ? a_q : '1;
        end else if (ovf_q) begin
            fix_val = op_q[1] ? '0 : a_q;
        end else begin
            unique case (op_q)
                3'b000:                 fix_val = prod_s[WIDTH-1:0];
                3'b001, 3'b010, 3'b011: fix_val = prod_s[2*WIDTH-1:WIDTH];
                3'b100, 3'b101:         fix_val = quo;
                3'b110, 3'b111:         fix_val = rem;
                default:                fix_val = '0;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        bmag_d    = bmag_q;
        a_d       = a_q;
        result_d  = result_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        divz_d    = divz_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (accept) begin
                    op_d      = Op;
                    a_d       = A;
                    hi_d      = '0;
                    lo_d      = a_mag;
                    bmag_d    = b_mag;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    divz_d    = divz_in;
                    ovf_d     = ovf_in;
                    cnt_d     = CW'(WIDTH - 1);
`ifdef MULDIV_EARLY_OUT_EN
                    state_d   = (divz_in || ovf_in) ? StFix : StCalc;
`else
                    state_d   = StCalc;
`endif
                end
            end
            StCalc: begin
                if (!op_q[2]) begin
                    if (lo_q[0]) begin
                        hi_d = mul_sum[WIDTH:1];
                        lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                    end else begin
                        hi_d = {1'b0, hi_q[WIDTH-1:1]};
                        lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
                    end
                end else if (r_shift >= {1'b0, bmag_q}) begin
                    hi_d = WIDTH'(r_shift - {1'b0, bmag_q});
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = r_shift[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StFix: begin
                result_d = fix_val;
                state_d  = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            op_q      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            bmag_q    <= '0;
            a_q       <= '0;
            result_q  <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            divz_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            bmag_q    <= bmag_d;
            a_q       <= a_d;
            result_q  <= result_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            divz_q    <= divz_d;
            ovf_q     <= ovf_d;
        end
    end

    assign result = result_q;
    assign busy   = (state_q == StCalc) || (state_q == StFix);
    assign done   = (state_q == StDone);
    assign Zero   = (result_q == '0);
    assign Sign   = result_q[WIDTH-1];

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH = 32): driver pushes expectations, monitor checks on done.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  Op;
    logic [31:0] A, B, result;
    logic        busy, done, Zero, Sign;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .Op     (Op),
        .A      (A),
        .B      (B),
        .result (result),
        .busy   (busy),
        .done   (done),
        .Zero   (Zero),
        .Sign   (Sign)
    );

    localparam int LAT = 34;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int LAT_SP = 2;
`else
    localparam int LAT_SP = 34;
`endif

    typedef struct {
        logic [31:0] res;
        int          at;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        bit          sp;
    } vec_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    vec_t vecs [0:18] = '{
        '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0},
        '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0},
        '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0},
        '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0},
        '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0},
        '{3'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 1'b0},
        '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0},
        '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0},
        '{3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 1'b0},
        '{3'd6, 32'h0000_0006, 32'h0000_0003, 32'h0000_0000, 1'b0},
        '{3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0},
        '{3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0},
        '{3'd7, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 1'b0},
        '{3'd5, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1},
        '{3'd7, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1'b1},
        '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1},
        '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1},
        '{3'd4, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1},
        '{3'd6, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 1'b1}
    };

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: every done pulse must match the oldest expectation.
    logic prev_done = 1'b0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (done) begin
            check("done_one_cycle", {31'b0, prev_done}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("result", result, e.res);
                check("zero", {31'b0, Zero}, {31'b0, e.res == 32'd0});
                check("sign", {31'b0, Sign}, {31'b0, e.res[31]});
                check("latency", 32'(cyc), 32'(e.at));
            end
        end
        prev_done = done;
    end

    task automatic wait_drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int lat);
        @(negedge clk);
        Op    = op;
        A     = a;
        B     = b;
        start = 1'b1;
        sb.push_back('{res: exp_res, at: cyc + lat});
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        Op    = 3'($urandom);
        wait_drain();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int k;
        int n_done;
        reset = 1'b1;
        start = 1'b0;
        Op    = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_result", result, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_zero", {31'b0, Zero}, 32'd1);
        check("rst_sign", {31'b0, Sign}, 32'd0);

        // Reset wins over start on the same edge.
        start = 1'b1;
        Op    = 3'd0;
        A     = 32'd9;
        B     = 32'd9;
        @(negedge clk);
        check("rst_prio_busy", {31'b0, busy}, 32'd0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("idle_busy", {31'b0, busy}, 32'd0);

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].sp ? LAT_SP : LAT);

        // Start held high: second op must begin exactly in the first op's DONE cycle.
        @(negedge clk);
        Op    = 3'd0;
        start = 1'b1;
        k     = 0;
        for (int i = 0; i < 120 && k < 3; i++) begin
            if (!busy) begin
                if (k == 2) begin
                    start = 1'b0;
                    k     = 3;
                end else begin
                    if (k == 1) check("restart_in_done", {31'b0, done}, 32'd1);
                    A = (k == 0) ? 32'd3 : 32'd5;
                    B = (k == 0) ? 32'd4 : 32'd6;
                    sb.push_back('{res: (k == 0) ? 32'd12 : 32'd30, at: cyc + LAT});
                    k++;
                end
            end else begin
                A = $urandom;
                B = $urandom;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("held_start_progress", 32'(k), 32'd3);
        wait_drain();

        // Reset in the 5th CALC cycle of a DIV aborts it silently.
        @(negedge clk);
        Op    = 3'd4;
        A     = 32'd100;
        B     = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A     = $urandom;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_zero", {31'b0, Zero}, 32'd1);
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);

        run_op(3'd0, 32'd3, 32'd5, 32'd15, LAT);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
